// File: rtl/mask_bbox.sv
// Per-frame bounding box of the binary paddle mask, with a minimum-pixel
// threshold and a hold-over of the last good box across short drop-outs.
module mask_bbox #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int MIN_COUNT  = 64,
    parameter int MISS_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        in_mask,
    input  logic [12:0] in_row,
    input  logic [12:0] in_col,
    output logic [12:0] T,
    output logic [12:0] B,
    output logic [12:0] L,
    output logic [12:0] R,
    output logic        sync,
    output logic        found,
    output logic [19:0] count,
    output logic        drop
);
    localparam int              MW        = $clog2(MISS_LIMIT + 2);
    localparam logic [12:0]     ROW_LIM   = 13'(V_ACTIVE);
    localparam logic [12:0]     COL_LIM   = 13'(H_ACTIVE);
    localparam logic [12:0]     ROW_LAST  = 13'(V_ACTIVE - 1);
    localparam logic [12:0]     COL_LAST  = 13'(H_ACTIVE - 1);
    localparam logic [19:0]     MIN_CNT   = 20'(MIN_COUNT);
    localparam logic [MW-1:0]   MISS_MAX  = MW'(MISS_LIMIT);
    localparam logic [12:0]     COORD_MAX = 13'h1fff;

    typedef enum logic {WAIT_SOF, ACCUM} state_t;

    state_t        state, state_nxt;
    logic [12:0]   min_r, max_r, min_c, max_c;
    logic [19:0]   cnt;
    logic [MW-1:0] miss_cnt, miss_inc;
    logic          accepted, sof, eof, commit, restart, hit, hold;
    logic [12:0]   nx_min_r, nx_max_r, nx_min_c, nx_max_c;
    logic [19:0]   nx_cnt;

    assign accepted = in_valid && (in_row < ROW_LIM) && (in_col < COL_LIM);
    assign sof      = accepted && (in_row == '0) && (in_col == '0);
    assign eof      = accepted && (in_row == ROW_LAST) && (in_col == COL_LAST);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset_n) state <= WAIT_SOF;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_nxt = state;
        commit    = 1'b0;
        restart   = 1'b0;
        case (state)
            WAIT_SOF: if (sof) state_nxt = ACCUM;
            ACCUM: begin
                if (sof) begin
                    restart = 1'b1;
                end else if (eof) begin
                    commit    = 1'b1;
                    state_nxt = WAIT_SOF;
                end
            end
            default: state_nxt = WAIT_SOF;
        endcase
    end

    // Accumulators including the current pixel; a SOF restarts them from empty.
    always_comb begin
        // NOTE: blocking = here chains the seed value into the min/max update within one cycle.
        nx_min_r = sof ? COORD_MAX : min_r;
        nx_max_r = sof ? '0 : max_r;
        nx_min_c = sof ? COORD_MAX : min_c;
        nx_max_c = sof ? '0 : max_c;
        nx_cnt   = sof ? '0 : cnt;
        if (accepted && in_mask) begin
            if (in_row < nx_min_r) nx_min_r = in_row;
            if (in_row > nx_max_r) nx_max_r = in_row;
            if (in_col < nx_min_c) nx_min_c = in_col;
            if (in_col > nx_max_c) nx_max_c = in_col;
            if (nx_cnt != '1) nx_cnt = nx_cnt + 20'd1;
        end
    end

    assign hit      = (nx_cnt >= MIN_CNT);
    assign miss_inc = (miss_cnt >= MISS_MAX) ? MISS_MAX : miss_cnt + MW'(1);
    assign hold     = (miss_inc < MISS_MAX);

    // NOTE: the accumulators carry no reset; they are always reloaded at SOF before being read.
    always_ff @(posedge clk) begin
        if (sof || (state == ACCUM && accepted)) begin
            min_r <= nx_min_r;
            max_r <= nx_max_r;
            min_c <= nx_min_c;
            max_c <= nx_max_c;
            cnt   <= nx_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            T        <= COORD_MAX;
            B        <= '0;
            L        <= COORD_MAX;
            R        <= '0;
            sync     <= 1'b0;
            found    <= 1'b0;
            count    <= '0;
            drop     <= 1'b0;
            miss_cnt <= '0;
        end else begin
            sync <= commit;
            drop <= restart;
            if (commit) begin
                count <= nx_cnt;
                found <= hit;
                if (hit) begin
                    T        <= nx_min_r;
                    B        <= nx_max_r;
                    L        <= nx_min_c;
                    R        <= nx_max_c;
                    miss_cnt <= '0;
                end else begin
                    miss_cnt <= miss_inc;
                    // Past the hold-over window the box becomes inverted so it can never overlap.
                    if (!hold) begin
                        T <= COORD_MAX;
                        B <= '0;
                        L <= COORD_MAX;
                        R <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mask_bbox.sv
// Bench for mask_bbox: a reduced 48x32 frame drives two instances (hold-over
// policy and single-pixel threshold) checked against a frame-level reference model.
module tb_mask_bbox;
    localparam int H = 48;
    localparam int V = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_mask = 1'b0;
    logic [12:0] in_row = '0;
    logic [12:0] in_col = '0;
    logic [12:0] t_o [2];
    logic [12:0] b_o [2];
    logic [12:0] l_o [2];
    logic [12:0] r_o [2];
    logic        sync_o [2];
    logic        found_o [2];
    logic        drop_o [2];
    logic [19:0] count_o [2];

    int vectors = 0;
    int miscompares = 0;
    int sync_seen [2] = '{0, 0};
    int drop_seen [2] = '{0, 0};
    int sync_exp = 0;
    int drop_exp = 0;
    bit frame_open = 1'b0;
    bit fm [V][H];

    int m_t [2], m_b [2], m_l [2], m_r [2], m_count [2], m_miss [2];
    bit m_found [2];

    always #5 clk = ~clk;

    mask_bbox #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(64), .MISS_LIMIT(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_mask(in_mask),
        .in_row(in_row), .in_col(in_col), .T(t_o[0]), .B(b_o[0]), .L(l_o[0]), .R(r_o[0]),
        .sync(sync_o[0]), .found(found_o[0]), .count(count_o[0]), .drop(drop_o[0]));

    mask_bbox #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(1), .MISS_LIMIT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_mask(in_mask),
        .in_row(in_row), .in_col(in_col), .T(t_o[1]), .B(b_o[1]), .L(l_o[1]), .R(r_o[1]),
        .sync(sync_o[1]), .found(found_o[1]), .count(count_o[1]), .drop(drop_o[1]));

    function automatic int min_p(input int k);
        return (k == 0) ? 64 : 1;
    endfunction

    function automatic int miss_lim(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    // Pulse counting and output-stability watch, sampled at the clock edge.
    logic [72:0] prev_o [2];
    bit rst_at_prev = 1'b0;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sync_o[k]) sync_seen[k]++;
            if (drop_o[k]) drop_seen[k]++;
            if (rst_at_prev && !sync_o[k]) begin
                vectors++;
                if ({t_o[k], b_o[k], l_o[k], r_o[k], found_o[k], count_o[k]} !== prev_o[k]) begin
                    miscompares++;
                    $display("FAIL stability dut%0d: outputs %h changed from %h without sync",
                             k, {t_o[k], b_o[k], l_o[k], r_o[k], found_o[k], count_o[k]}, prev_o[k]);
                end
            end
            prev_o[k] = {t_o[k], b_o[k], l_o[k], r_o[k], found_o[k], count_o[k]};
        end
        rst_at_prev = reset_n;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit v, input bit m, input int r, input int c);
        in_valid = v;
        in_mask  = m;
        in_row   = 13'(r);
        in_col   = 13'(c);
        @(negedge clk);
    endtask

    // One idle cycle: either in_valid=0 or a set pixel outside the active area.
    task automatic idle_cycle();
        if ($urandom_range(1) == 0)
            drive(1'b0, 1'($urandom_range(1)), $urandom_range(V - 1), $urandom_range(H - 1));
        else if ($urandom_range(1) == 0)
            drive(1'b1, 1'b1, V + $urandom_range(200), $urandom_range(H - 1));
        else
            drive(1'b1, 1'b1, $urandom_range(V - 1), H + $urandom_range(200));
    endtask

    task automatic fill_rect(input int r0, input int r1, input int c0, input int c1);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                fm[r][c] = (r >= r0 && r <= r1 && c >= c0 && c <= c1);
    endtask

    task automatic fill_random(input int pct);
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                fm[r][c] = ($urandom_range(99) < pct);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t[k] = 8191; m_b[k] = 0; m_l[k] = 8191; m_r[k] = 0;
            m_found[k] = 1'b0; m_count[k] = 0; m_miss[k] = 0;
        end
        frame_open = 1'b0;
    endtask

    // Frame-level reference: box and count from the whole stored mask, then the hit/miss policy.
    task automatic model_commit();
        int cnt = 0, mnr = 8191, mxr = 0, mnc = 8191, mxc = 0;
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                if (fm[r][c]) begin
                    cnt++;
                    mnr = (r < mnr) ? r : mnr;
                    mxr = (r > mxr) ? r : mxr;
                    mnc = (c < mnc) ? c : mnc;
                    mxc = (c > mxc) ? c : mxc;
                end
        for (int k = 0; k < 2; k++) begin
            m_count[k] = cnt;
            if (cnt >= min_p(k)) begin
                m_t[k] = mnr; m_b[k] = mxr; m_l[k] = mnc; m_r[k] = mxc;
                m_found[k] = 1'b1;
                m_miss[k] = 0;
            end else begin
                m_found[k] = 1'b0;
                m_miss[k] = (m_miss[k] < miss_lim(k)) ? m_miss[k] + 1 : miss_lim(k);
                if (m_miss[k] >= miss_lim(k)) begin
                    m_t[k] = 8191; m_b[k] = 0; m_l[k] = 8191; m_r[k] = 0;
                end
            end
        end
    endtask

    // Streams the stored mask raster-order; cut_at>0 stops after that many pixels (no EOF).
    task automatic send_frame(input string tag, input int idle_pct, input int cut_at);
        int n = 0;
        int s0 [2];
        for (int k = 0; k < 2; k++) s0[k] = sync_seen[k];
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                while ($urandom_range(99) < idle_pct) idle_cycle();
                drive(1'b1, fm[r][c], r, c);
                if (r == 0 && c == 0) begin
                    if (frame_open) drop_exp++;
                    for (int k = 0; k < 2; k++) begin
                        vectors++;
                        if (drop_o[k] !== frame_open) begin
                            miscompares++;
                            $display("FAIL %s dut%0d drop after SOF: got %b expected %b",
                                     tag, k, drop_o[k], frame_open);
                        end
                    end
                    frame_open = 1'b1;
                end
                n++;
                if (cut_at > 0 && n == cut_at) return;
            end
        end
        frame_open = 1'b0;
        sync_exp++;
        model_commit();
        for (int k = 0; k < 2; k++) begin
            vectors += 7;
            if (sync_o[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL %s dut%0d sync after EOF: got %b expected 1", tag, k, sync_o[k]);
            end
            if (t_o[k] !== 13'(m_t[k])) begin
                miscompares++;
                $display("FAIL %s dut%0d T: got %0d expected %0d", tag, k, t_o[k], m_t[k]);
            end
            if (b_o[k] !== 13'(m_b[k])) begin
                miscompares++;
                $display("FAIL %s dut%0d B: got %0d expected %0d", tag, k, b_o[k], m_b[k]);
            end
            if (l_o[k] !== 13'(m_l[k])) begin
                miscompares++;
                $display("FAIL %s dut%0d L: got %0d expected %0d", tag, k, l_o[k], m_l[k]);
            end
            if (r_o[k] !== 13'(m_r[k])) begin
                miscompares++;
                $display("FAIL %s dut%0d R: got %0d expected %0d", tag, k, r_o[k], m_r[k]);
            end
            if (found_o[k] !== m_found[k]) begin
                miscompares++;
                $display("FAIL %s dut%0d found: got %b expected %b", tag, k, found_o[k], m_found[k]);
            end
            if (count_o[k] !== 20'(m_count[k])) begin
                miscompares++;
                $display("FAIL %s dut%0d count: got %0d expected %0d", tag, k, count_o[k], m_count[k]);
            end
        end
        drive(1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (sync_o[k] !== 1'b0) begin
                miscompares++;
                $display("FAIL %s dut%0d sync second cycle: got %b expected 0", tag, k, sync_o[k]);
            end
        end
        drive(1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (sync_seen[k] - s0[k] != 1) begin
                miscompares++;
                $display("FAIL %s dut%0d sync pulses: got %0d expected 1", tag, k, sync_seen[k] - s0[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) drive(1'b1, 1'b1, 0, 0);
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({t_o[k], b_o[k], l_o[k], r_o[k], sync_o[k], found_o[k], count_o[k], drop_o[k]}
                !== {13'd8191, 13'd0, 13'd8191, 13'd0, 1'b0, 1'b0, 20'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset dut%0d: T=%0d B=%0d L=%0d R=%0d sync=%b found=%b count=%0d drop=%b, expected 8191 0 8191 0 0 0 0 0",
                         k, t_o[k], b_o[k], l_o[k], r_o[k], sync_o[k], found_o[k], count_o[k], drop_o[k]);
            end
        end
    endtask

    task automatic test_rect();
        fill_rect(10, 19, 5, 24);
        send_frame("rect", 0, 0);
    endtask

    task automatic test_hold();
        fill_rect(10, 20, 30, 40);
        send_frame("hold_hit", 5, 0);
        for (int i = 1; i <= 4; i++) begin
            fill_rect(2, 4, 0, 20);
            send_frame($sformatf("hold_miss%0d", i), 5, 0);
        end
        fill_rect(10, 20, 30, 40);
        send_frame("hold_recover", 5, 0);
    endtask

    task automatic test_corners();
        fill_rect(0, 0, 0, 0);
        send_frame("corner_sof", 25, 0);
        fill_rect(V - 1, V - 1, H - 1, H - 1);
        send_frame("corner_eof", 25, 0);
    endtask

    task automatic test_drop();
        int d0 = drop_seen[0], d1 = drop_seen[1], s0 = sync_seen[0];
        fill_rect(3, 8, 3, 9);
        send_frame("cut", 10, 1000);
        fill_rect(5, 25, 10, 40);
        send_frame("after_cut", 10, 0);
        vectors += 3;
        if (drop_seen[0] - d0 != 1 || drop_seen[1] - d1 != 1) begin
            miscompares++;
            $display("FAIL drop pulses: got %0d/%0d expected 1/1", drop_seen[0] - d0, drop_seen[1] - d1);
        end
        if (sync_seen[0] - s0 != 1) begin
            miscompares++;
            $display("FAIL cut sync pulses: got %0d expected 1", sync_seen[0] - s0);
        end
        if (drop_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL drop width: got %b expected 0", drop_o[0]);
        end
    endtask

    task automatic test_gaps();
        fill_rect(10, 19, 5, 24);
        send_frame("gaps_rect", 30, 0);
        for (int i = 0; i < 3; i++) begin
            fill_random($urandom_range(1, 8));
            send_frame($sformatf("gaps_rand%0d", i), 30, 0);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        fill_rect(10, 20, 30, 40);
        send_frame("pre_reset_hit", 0, 0);
        fill_rect(2, 4, 0, 20);
        send_frame("pre_reset_miss", 0, 0);
        send_frame("mid_cut", 10, 500);
        test_reset();
        s0 = sync_seen[0];
        repeat (5) idle_cycle();
        drive(1'b1, 1'b1, V - 1, H - 1);
        repeat (3) drive(1'b0, 1'b0, 0, 0);
        vectors++;
        if (sync_seen[0] != s0) begin
            miscompares++;
            $display("FAIL orphan EOF sync: got %0d pulses expected 0", sync_seen[0] - s0);
        end
        fill_rect(2, 4, 0, 20);
        send_frame("post_reset_miss", 10, 0);
        fill_rect(6, 9, 1, 46);
        send_frame("post_reset_hit", 10, 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_rect();
        test_hold();
        test_corners();
        test_drop();
        test_gaps();
        test_reset_mid();
        vectors += 2;
        if (sync_seen[0] != sync_exp || sync_seen[1] != sync_exp) begin
            miscompares++;
            $display("FAIL total sync: got %0d/%0d expected %0d", sync_seen[0], sync_seen[1], sync_exp);
        end
        if (drop_seen[0] != drop_exp || drop_seen[1] != drop_exp) begin
            miscompares++;
            $display("FAIL total drop: got %0d/%0d expected %0d", drop_seen[0], drop_seen[1], drop_exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mask_bbox.md
# mask_bbox

Per-frame bounding-box extractor for the denoised HSV colour mask. It consumes the pixel stream of the binary mask (one bit per active pixel, with row/column coordinates) and accumulates min/max row/column of set pixels across the frame. At the end of each frame it publishes the paddle box as T/B/L/R together with a one-cycle `sync` pulse, and feeds these directly to the ball-motion stage. It also applies a minimum-pixel threshold and a hold-over policy so that brief detection drop-outs do not make the paddle vanish.

## Interface
- `H_ACTIVE`, 640, active pixels per line.
- `V_ACTIVE`, 480, active lines per frame.
- `MIN_COUNT`, 64, minimum set-pixel count for a frame to count as a hit.
- `MISS_LIMIT`, 4, consecutive miss frames during which the last good box is held.
- `clk`  in  1  pixel clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  pixel qualifier.
- `in_mask`  in  1  denoised mask bit (1 = paddle colour).
- `in_row`  in  13  pixel row.
- `in_col`  in  13  pixel column.
- `T`, `B`, `L`, `R`  out  13 each  registered box: top/bottom row, left/right column.
- `sync`  out  1  one-cycle pulse when a new box is published.
- `found`  out  1  1 = published box comes from the frame just ended.
- `count`  out  20  set-pixel count of the frame just ended.
- `drop`  out  1  one-cycle pulse when a partial frame is discarded.

## Operation
- A pixel is accepted when `in_valid`=1, `in_row`<V_ACTIVE and `in_col`<H_ACTIVE. Other pixels are ignored entirely.
- SOF is an accepted pixel at (0,0). EOF is an accepted pixel at (V_ACTIVE-1, H_ACTIVE-1).
- FSM states:
  - WAIT_SOF: entered at reset. On SOF, go to ACCUM and initialise the accumulators with the SOF pixel.
  - ACCUM: on EOF, include the EOF pixel, commit, and return to WAIT_SOF. If a SOF arrives in ACCUM, pulse `drop`, discard the partial data, re-initialise with the SOF pixel and stay in ACCUM. There is no commit for the dropped frame.
- Accumulator initial values: min_r = min_c = 8191, max_r = max_c = 0, cnt = 0.
- For each accepted pixel with `in_mask`=1:
  - min_r = min(min_r,row); max_r = max(max_r,row); likewise for columns.
  - cnt += 1, saturating at 2^20-1.
- Commit is a hit when cnt ≥ MIN_COUNT. A hit does the following:
  - T=min_r, B=max_r, L=min_c, R=max_c.
  - `found`=1 and miss_cnt=0.
- Commit is a miss otherwise:
  - `found`=0, and miss_cnt increments, saturating at MISS_LIMIT.
  - If the incremented miss_cnt ≤ MISS_LIMIT−1, T/B/L/R hold their previous values.
  - Otherwise the outputs take the empty box T=8191, B=0, L=8191, R=0. Because T>B and L>R, the box can never satisfy the downstream paddle-overlap tests.
  - With MISS_LIMIT=0, every miss produces the empty box immediately.
- `count` takes cnt on every commit, whether hit or miss.
- All comparisons are unsigned 13-bit.

## Timing
- Reset values: T=8191, B=0, L=8191, R=0, `sync`=0, `found`=0, `count`=0, `drop`=0. Internally, miss_cnt=0 and FSM=WAIT_SOF. Reset overrides every other event in the same cycle.
- Latency:
  - EOF pixel accepted in cycle n → T/B/L/R/`found`/`count` updated and `sync`=1 in cycle n+1.
  - `sync`=0 in cycle n+2.
- `drop` is asserted in the cycle after the offending SOF, for one cycle.
- Outputs remain stable between `sync` pulses. Downstream may sample them on any cycle.
- Gaps (`in_valid`=0) of any length are allowed inside a frame.
- Reset asserted mid-frame: the partial frame is lost, no `sync` is issued, and the block waits for the next SOF.
- An EOF seen in WAIT_SOF (no preceding SOF) is ignored: no `sync`.

## Test plan
- Reset, then a full 640×480 frame with mask=1 only in the rectangle rows 100–149, cols 200–299 → one `sync` after EOF with T=100, B=149, L=200, R=299, `found`=1, `count`=5000.
- Frame with exactly 63 set pixels, preceded by a hit frame with box (10,20,30,40) → `found`=0, box held at (10,20,30,40), `count`=63. Repeat 63-pixel frames: the box is held for frames 1–3 and becomes empty (8191,0,8191,0) on frame 4.
- Frame with a single pixel at (0,0) and MIN_COUNT=1 → T=B=L=R=0. Frame with a single pixel at (479,639) → T=B=479, L=R=639. Set pixels outside the active area are ignored.
- Frame cut after 1000 pixels by a new SOF → `drop` pulses once, no `sync`, and the following complete frame is reported correctly.
- Random `in_valid` gaps (about 30% idle) with the same mask as the first scenario → identical outputs. `sync` occurs exactly one cycle after the EOF pixel.
- reset_n pulsed low mid-frame → outputs return to reset values, miss_cnt clears, and there is no `sync` until a full SOF…EOF frame completes.
